// File: rtl/vec_wb_collector_if.sv
// Lane-result and register-file write-port bundle for the vector write-back collector.
// The master side feeds lane beats and accepts writes; the slave side is the collector.
interface vec_wb_collector_if #(
  parameter int VLEN = 128
);
  logic              start;
  logic [4:0]        vd_addr;
  logic [2:0]        vsew;
  logic [1:0]        nb_lanes;
  logic              valid0, valid1, valid2, valid3;
  logic [63:0]       vd0, vd1, vd2, vd3;
  logic [9:0]        regi0, regi1, regi2, regi3;
  logic              done0, done1, done2, done3;
  logic              busy;
  logic              wr_valid;
  logic              wr_ready;
  logic [4:0]        wr_addr;
  logic [VLEN-1:0]   wr_data;
  logic [VLEN/8-1:0] wr_be;
  logic              wb_done;
  logic              ovf;

  modport master (
    output start, vd_addr, vsew, nb_lanes,
    output valid0, valid1, valid2, valid3,
    output vd0, vd1, vd2, vd3,
    output regi0, regi1, regi2, regi3,
    output done0, done1, done2, done3,
    output wr_ready,
    input  busy, wr_valid, wr_addr, wr_data, wr_be, wb_done, ovf
  );

  modport slave (
    input  start, vd_addr, vsew, nb_lanes,
    input  valid0, valid1, valid2, valid3,
    input  vd0, vd1, vd2, vd3,
    input  regi0, regi1, regi2, regi3,
    input  done0, done1, done2, done3,
    input  wr_ready,
    output busy, wr_valid, wr_addr, wr_data, wr_be, wb_done, ovf
  );
endinterface

// File: rtl/vec_wb_collector.sv
// Vector write-back collector: merges per-lane result chunks into a VLEN-bit staging
// register with byte enables, then offers it to the register file over valid/ready.
module vec_wb_collector #(
  parameter int VLEN       = 128,
  parameter int LANE_WIDTH = 4
) (
  input logic               clk,
  input logic               reset,
  vec_wb_collector_if.slave bus
);
  localparam int NLANES    = 4;
  localparam int CHUNK_MAX = 1 << LANE_WIDTH;
  localparam int NBYTES    = VLEN / 8;
  localparam int IDXW      = $clog2(VLEN);

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE} state_t;

  state_t            r_state, w_stateNext;
  logic [4:0]        r_addr;
  logic [2:0]        r_vsew;
  logic [1:0]        r_nbLanes;
  logic [VLEN-1:0]   r_data, w_dataNext;
  logic [NBYTES-1:0] r_be, w_beNext;
  logic              r_ovf, w_ovfNext;
  logic              r_wbDone, w_wbDoneNext;
  logic              w_anyDone;
  logic [IDXW-1:0]   w_bitIdx;
  int                w_width;
  int                w_lo;

  logic [NLANES-1:0] w_valid, w_done;
  logic [63:0]       w_vd   [NLANES];
  logic [9:0]        w_regi [NLANES];

  assign w_valid = {bus.valid3, bus.valid2, bus.valid1, bus.valid0};
  assign w_done  = {bus.done3, bus.done2, bus.done1, bus.done0};
  assign w_vd[0] = bus.vd0;
  assign w_vd[1] = bus.vd1;
  assign w_vd[2] = bus.vd2;
  assign w_vd[3] = bus.vd3;
  assign w_regi[0] = bus.regi0;
  assign w_regi[1] = bus.regi1;
  assign w_regi[2] = bus.regi2;
  assign w_regi[3] = bus.regi3;

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_stateNext;
  end

  // Lanes are visited in ascending order so the highest-numbered lane wins overlaps.
  always_comb begin
    w_stateNext  = r_state;
    w_dataNext   = r_data;
    w_beNext     = r_be;
    w_ovfNext    = r_ovf;
    w_wbDoneNext = 1'b0;
    w_anyDone    = 1'b0;
    w_bitIdx     = '0;
    w_lo         = 0;
    w_width      = 8 << r_vsew;
    if (w_width > CHUNK_MAX) w_width = CHUNK_MAX;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_dataNext  = '0;
          w_beNext    = '0;
          w_ovfNext   = 1'b0;
          w_stateNext = COLLECT;
        end
      end
      COLLECT: begin
        for (int i = 0; i < NLANES; i++) begin
          if (i <= int'(r_nbLanes) && w_valid[i]) begin
            w_lo = int'(w_regi[i]);
            if (w_lo + w_width <= VLEN) begin
              for (int j = 0; j < CHUNK_MAX; j++) begin
                if (j < w_width) begin
                  w_bitIdx = IDXW'(w_lo + j);
                  w_dataNext[w_bitIdx] = w_vd[i][j];
                end
              end
              for (int k = 0; k < NBYTES; k++) begin
                if (k >= w_lo / 8 && k <= (w_lo + w_width - 1) / 8) w_beNext[k] = 1'b1;
              end
            end else begin
              w_ovfNext = 1'b1;
            end
            if (w_done[i]) w_anyDone = 1'b1;
          end
        end
        if (w_anyDone) w_stateNext = WRITE;
      end
      WRITE: begin
        if (bus.wr_ready) begin
          w_stateNext  = IDLE;
          w_wbDoneNext = 1'b1;
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  // Staging register and latched command fields; they persist after the write until the next start.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr    <= '0;
      r_vsew    <= '0;
      r_nbLanes <= '0;
      r_data    <= '0;
      r_be      <= '0;
      r_ovf     <= 1'b0;
      r_wbDone  <= 1'b0;
    end else begin
      r_data   <= w_dataNext;
      r_be     <= w_beNext;
      r_ovf    <= w_ovfNext;
      r_wbDone <= w_wbDoneNext;
      if (r_state == IDLE && bus.start) begin
        r_addr    <= bus.vd_addr;
        r_vsew    <= bus.vsew;
        r_nbLanes <= bus.nb_lanes;
      end
    end
  end

  assign bus.busy     = (r_state != IDLE);
  assign bus.wr_valid = (r_state == WRITE);
  assign bus.wr_addr  = r_addr;
  assign bus.wr_data  = r_data;
  assign bus.wr_be    = r_be;
  assign bus.wb_done  = r_wbDone;
  assign bus.ovf      = r_ovf;
endmodule

// File: tb/tb_vec_wb_collector.sv
// Self-checking bench for vec_wb_collector: table-driven single-beat vectors, directed
// multi-cycle sequences, and randomized collections against a bit-mask reference model.
module tb_vec_wb_collector;
  localparam int VLEN = 128;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vec_wb_collector_if #(.VLEN(VLEN)) bus ();
  vec_wb_collector #(.VLEN(VLEN), .LANE_WIDTH(4)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic [2:0]        vsew;
    logic [1:0]        nb;
    logic [4:0]        addr;
    logic [3:0]        valid;
    logic [3:0][9:0]   regi;
    logic [3:0][63:0]  vd;
    logic [127:0]      expData;
    logic [15:0]       expBe;
    logic              expOvf;
  } vec_t;

  vec_t tbl[5];
  int vectors = 0;
  int miscompares = 0;

  logic        lValid [4];
  logic        lDone  [4];
  logic [9:0]  lRegi  [4];
  logic [63:0] lVd    [4];

  logic [127:0] mData;
  logic [15:0]  mBe;
  logic         mOvf;
  logic [2:0]   mVsew;
  logic [1:0]   mNb;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic driveLanes();
    bus.valid0 = lValid[0]; bus.valid1 = lValid[1]; bus.valid2 = lValid[2]; bus.valid3 = lValid[3];
    bus.done0  = lDone[0];  bus.done1  = lDone[1];  bus.done2  = lDone[2];  bus.done3  = lDone[3];
    bus.regi0  = lRegi[0];  bus.regi1  = lRegi[1];  bus.regi2  = lRegi[2];  bus.regi3  = lRegi[3];
    bus.vd0    = lVd[0];    bus.vd1    = lVd[1];    bus.vd2    = lVd[2];    bus.vd3    = lVd[3];
  endtask

  task automatic clearLanes();
    for (int i = 0; i < 4; i++) begin
      lValid[i] = 1'b0; lDone[i] = 1'b0; lRegi[i] = '0; lVd[i] = '0;
    end
    driveLanes();
  endtask

  // Reference: each in-range chunk is a mask-and-shift insert; a byte is enabled if the mask touches it.
  task automatic modelBeat();
    int w;
    logic [127:0] mask, placed;
    w = 8 << mVsew;
    if (w > 16) w = 16;
    mask = (128'd1 << w) - 128'd1;
    for (int i = 0; i <= int'(mNb); i++) begin
      if (lValid[i]) begin
        if (int'(lRegi[i]) + w <= VLEN) begin
          placed = mask << lRegi[i];
          mData  = (mData & ~placed) | (({64'd0, lVd[i]} & mask) << lRegi[i]);
          for (int k = 0; k < 16; k++)
            if (((placed >> (8 * k)) & 128'hFF) != 128'd0) mBe[k] = 1'b1;
        end else begin
          mOvf = 1'b1;
        end
      end
    end
  endtask

  task automatic applyStimulus(input logic [4:0] addr, input logic [2:0] vsew, input logic [1:0] nb);
    bus.start = 1'b1; bus.vd_addr = addr; bus.vsew = vsew; bus.nb_lanes = nb;
    tick();
    bus.start = 1'b0;
    mData = '0; mBe = '0; mOvf = 1'b0; mVsew = vsew; mNb = nb;
    checkOutput("busy_after_start", {127'd0, bus.busy}, 128'd1);
    checkOutput("ovf_cleared_on_start", {127'd0, bus.ovf}, 128'd0);
  endtask

  task automatic beat();
    driveLanes();
    tick();
    modelBeat();
    clearLanes();
  endtask

  task automatic finishWrite(input string tag, input logic [4:0] addr, input logic [127:0] data,
                             input logic [15:0] be, input logic ovf);
    checkOutput({tag, "_wr_valid"}, {127'd0, bus.wr_valid}, 128'd1);
    checkOutput({tag, "_wr_addr"}, {123'd0, bus.wr_addr}, {123'd0, addr});
    checkOutput({tag, "_wr_data"}, bus.wr_data, data);
    checkOutput({tag, "_wr_be"}, {112'd0, bus.wr_be}, {112'd0, be});
    checkOutput({tag, "_ovf"}, {127'd0, bus.ovf}, {127'd0, ovf});
    bus.wr_ready = 1'b1;
    tick();
    bus.wr_ready = 1'b0;
    checkOutput({tag, "_valid_drop"}, {126'd0, bus.wr_valid, bus.busy}, 128'd0);
    checkOutput({tag, "_wb_done"}, {127'd0, bus.wb_done}, 128'd1);
    tick();
    checkOutput({tag, "_wb_done_pulse"}, {127'd0, bus.wb_done}, 128'd0);
    checkOutput({tag, "_data_held"}, bus.wr_data, data);
  endtask

  task automatic setVec(input int n, input logic [2:0] vsew, input logic [1:0] nb, input logic [4:0] addr,
                        input logic [3:0] valid, input logic [3:0][9:0] regi, input logic [3:0][63:0] vd,
                        input logic [127:0] expData, input logic [15:0] expBe, input logic expOvf);
    tbl[n].vsew = vsew; tbl[n].nb = nb; tbl[n].addr = addr; tbl[n].valid = valid;
    tbl[n].regi = regi; tbl[n].vd = vd;
    tbl[n].expData = expData; tbl[n].expBe = expBe; tbl[n].expOvf = expOvf;
  endtask

  initial begin
    int nBeats, d;
    reset = 1'b1;
    bus.start = 1'b0; bus.vd_addr = '0; bus.vsew = '0; bus.nb_lanes = '0; bus.wr_ready = 1'b0;
    clearLanes();

    setVec(0, 3'd0, 2'd3, 5'd5, 4'b1111, {10'd24, 10'd16, 10'd8, 10'd0},
           {64'h44, 64'h33, 64'h22, 64'h11}, 128'h4433_2211, 16'h000F, 1'b0);
    setVec(1, 3'd0, 2'd3, 5'd9, 4'b0101, {10'd0, 10'd8, 10'd0, 10'd8},
           {64'h0, 64'h77, 64'h0, 64'h55}, 128'h7700, 16'h0002, 1'b0);
    setVec(2, 3'd1, 2'd1, 5'd31, 4'b0011, {10'd0, 10'd0, 10'd113, 10'd112},
           {64'h0, 64'h0, 64'h1111, 64'hCAFE}, 128'hCAFE << 112, 16'hC000, 1'b1);
    setVec(3, 3'd0, 2'd0, 5'd1, 4'b0001, {10'd0, 10'd0, 10'd0, 10'd3},
           {64'h0, 64'h0, 64'h0, 64'h1FF}, 128'h7F8, 16'h0003, 1'b0);
    setVec(4, 3'd3, 2'd2, 5'd17, 4'b1100, {10'd0, 10'd64, 10'd0, 10'd0},
           {64'hFF, 64'hFFFF_FFFF_1234_ABCD, 64'h0, 64'h0}, 128'hABCD << 64, 16'h0300, 1'b0);

    tick(); tick();
    reset = 1'b0;
    checkOutput("reset_ctrl", {124'd0, bus.busy, bus.wr_valid, bus.wb_done, bus.ovf}, 128'd0);
    checkOutput("reset_wr_addr", {123'd0, bus.wr_addr}, 128'd0);
    checkOutput("reset_wr_data", bus.wr_data, 128'd0);
    checkOutput("reset_wr_be", {112'd0, bus.wr_be}, 128'd0);

    for (int n = 0; n < 5; n++) begin
      applyStimulus(tbl[n].addr, tbl[n].vsew, tbl[n].nb);
      for (int i = 0; i < 4; i++) begin
        lValid[i] = tbl[n].valid[i]; lDone[i] = tbl[n].valid[i];
        lRegi[i] = tbl[n].regi[i];   lVd[i] = tbl[n].vd[i];
      end
      beat();
      finishWrite($sformatf("tbl%0d", n), tbl[n].addr, tbl[n].expData, tbl[n].expBe, tbl[n].expOvf);
    end

    // Two beats into one register, then backpressure while start and lane beats are presented.
    applyStimulus(5'd7, 3'd2, 2'd0);
    lValid[0] = 1'b1; lRegi[0] = 10'd0; lVd[0] = 64'hBEEF;
    beat();
    checkOutput("beef_no_valid_yet", {127'd0, bus.wr_valid}, 128'd0);
    lValid[0] = 1'b1; lDone[0] = 1'b1; lRegi[0] = 10'd16; lVd[0] = 64'hDEAD;
    beat();
    for (int c = 0; c < 5; c++) begin
      bus.start = 1'b1; bus.vd_addr = 5'd2;
      lValid[0] = 1'b1; lDone[0] = 1'b1; lRegi[0] = 10'd0; lVd[0] = 64'h5A5A;
      driveLanes();
      tick();
      checkOutput("bp_wr_valid", {127'd0, bus.wr_valid}, 128'd1);
      checkOutput("bp_wr_data", bus.wr_data, 128'hDEAD_BEEF);
      checkOutput("bp_wr_be", {112'd0, bus.wr_be}, 128'h000F);
    end
    bus.start = 1'b0;
    clearLanes();
    finishWrite("backpressure", 5'd7, 128'hDEAD_BEEF, 16'h000F, 1'b0);

    // Out-of-range chunk plus a beat on an inactive lane.
    applyStimulus(5'd12, 3'd1, 2'd0);
    lValid[0] = 1'b1; lRegi[0] = 10'd120; lVd[0] = 64'hFFFF;
    lValid[1] = 1'b1; lRegi[1] = 10'd32;  lVd[1] = 64'hAAAA;
    beat();
    lValid[0] = 1'b1; lDone[0] = 1'b1; lRegi[0] = 10'd0; lVd[0] = 64'h1234;
    beat();
    finishWrite("ovf_inactive", 5'd12, 128'h1234, 16'h0003, 1'b1);

    // Reset mid-collection must abort cleanly with no stale data in the next register.
    applyStimulus(5'd3, 3'd0, 2'd0);
    lValid[0] = 1'b1; lRegi[0] = 10'd0; lVd[0] = 64'hAB;
    beat();
    lValid[0] = 1'b1; lRegi[0] = 10'd8; lVd[0] = 64'hCD;
    beat();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("abort_ctrl", {124'd0, bus.busy, bus.wr_valid, bus.wb_done, bus.ovf}, 128'd0);
    checkOutput("abort_wr_data", bus.wr_data, 128'd0);
    checkOutput("abort_wr_be", {112'd0, bus.wr_be}, 128'd0);
    applyStimulus(5'd4, 3'd0, 2'd0);
    checkOutput("abort_no_valid", {127'd0, bus.wr_valid}, 128'd0);
    lValid[0] = 1'b1; lDone[0] = 1'b1; lRegi[0] = 10'd0; lVd[0] = 64'h01;
    beat();
    finishWrite("after_abort", 5'd4, 128'h01, 16'h0001, 1'b0);

    // Randomized collections against the reference model.
    for (int n = 0; n < 30; n++) begin
      applyStimulus(5'($urandom_range(0, 31)), 3'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      nBeats = $urandom_range(1, 4);
      for (int b = 0; b < nBeats; b++) begin
        for (int i = 0; i < 4; i++) begin
          lValid[i] = 1'($urandom_range(0, 1));
          lRegi[i]  = 10'($urandom_range(0, 135));
          lVd[i]    = {$urandom, $urandom};
          lDone[i]  = (i > int'(mNb)) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        if (b == nBeats - 1) begin
          d = $urandom_range(0, int'(mNb));
          lValid[d] = 1'b1;
          lDone[d]  = 1'b1;
        end
        beat();
        if (b != nBeats - 1) checkOutput("rnd_no_early_valid", {127'd0, bus.wr_valid}, 128'd0);
      end
      for (int c = $urandom_range(0, 2); c > 0; c--) begin
        tick();
        checkOutput("rnd_valid_hold", {127'd0, bus.wr_valid}, 128'd1);
      end
      finishWrite($sformatf("rnd%0d", n), bus.vd_addr, mData, mBe, mOvf);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/vec_wb_collector.md
# vec_wb_collector

Write-back collector at the output end of the vector ALU lane array. Accepts per-lane result chunks (data, destination bit index, last-beat flag) from up to four lanes. Merges them into a VLEN-bit staging buffer with per-byte enables. Presents the assembled destination register to the vector register file through a valid/ready write port.

## Interface
Parameters:
- VLEN, 128: vector register width in bits; multiple of 64.
- LANE_WIDTH, 4: log2 of the maximum chunk width per lane beat, so a beat carries at most 16 bits.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begins collection of a new destination register; sampled only in IDLE.
- vd_addr  in  5  destination register number; latched on an accepted start.
- vsew  in  3  element width code (element width = 8<<vsew bits); latched on an accepted start.
- nb_lanes  in  2  number of active lanes minus 1; latched on an accepted start.
- valid0..valid3  in  1 each  lane i beat qualifier.
- vd0..vd3  in  64 each  lane i result; only the low W bits are used.
- regi0..regi3  in  10 each  bit index in the destination where the lane i chunk starts.
- done0..done3  in  1 each  lane i last beat; qualified by valid_i.
- busy  out  1  high in COLLECT and WRITE.
- wr_valid  out  1  write request to the register file.
- wr_ready  in  1  register file accepts the write.
- wr_addr  out  5  latched vd_addr.
- wr_data  out  VLEN  assembled register.
- wr_be  out  VLEN/8  byte enables; a bit is set for every byte touched by an accepted chunk.
- wb_done  out  1  one-cycle pulse after the write is accepted.
- ovf  out  1  sticky; at least one chunk was dropped as out of range. Cleared on an accepted start.

## Operation
- Chunk width rule: W = 8<<vsew_latched when 8<<vsew_latched ≤ 1<<LANE_WIDTH, otherwise W = 1<<LANE_WIDTH.
  - With the default LANE_WIDTH: vsew 0 gives W = 8; vsew ≥ 1 gives W = 16.
- Active lanes: i ≤ nb_lanes_latched. valid/done on inactive lanes are ignored.
- States: IDLE, COLLECT, WRITE.
- IDLE: busy=0, wr_valid=0.
  - start=1: clear the buffer and wr_be, clear ovf, latch vd_addr/vsew/nb_lanes, go to COLLECT.
- COLLECT: each cycle, every active lane with valid_i=1 is merged.
  - If regi_i + W ≤ VLEN: buffer[regi_i +: W] ← vd_i[W-1:0], and wr_be bytes regi_i>>3 through (regi_i+W-1)>>3 are set. Unaligned regi is legal.
  - Otherwise the chunk is dropped and ovf is set.
  - Overlapping chunks in the same cycle: the highest-numbered lane wins.
  - Later cycles overwrite earlier ones.
  - Any active lane with valid_i & done_i: that cycle's data is still merged, then the block moves to WRITE.
  - start is ignored.
- WRITE: wr_valid=1. wr_addr, wr_data and wr_be are held stable.
  - Lane inputs and start are ignored.
  - wr_ready=1: go to IDLE, pulse wb_done.
- Bits not written during a collection read as 0 in wr_data. Their wr_be bits are 0.

## Timing
- Reset values: busy=0, wr_valid=0, wr_addr=0, wr_data=0, wr_be=0, wb_done=0, ovf=0, state=IDLE.
- start at cycle t in IDLE: busy=1 at t+1.
- Beat at cycle t: visible in wr_data/wr_be from t+1.
- Valid done at t: wr_valid=1 at t+1.
  - Minimum start-to-write latency is 2 cycles: start at t, single done beat at t+1, wr_valid at t+2.
- wr_valid & wr_ready at t: at t+1, wr_valid=0, busy=0, wb_done=1; wb_done returns to 0 at t+2.
- start at t+1 (IDLE) is accepted. Back-to-back writes need no gap beyond that.
- wr_data, wr_be and ovf remain at their last values after wb_done until the next accepted start.
- reset during COLLECT or WRITE: all outputs take their reset values on the next edge, and no wr_valid or wb_done is produced for the aborted register.

## Test plan
- vsew=0, nb_lanes=3, start with vd_addr=5, one beat on all lanes with done: regi 0/8/16/24, data 0x11/0x22/0x33/0x44 -> wr_addr=5, wr_data[31:0]=0x44332211, upper bits 0, wr_be=0x000F, ovf=0.
- vsew=2, nb_lanes=0:
  - lane0 beat regi=0, data 0xBEEF.
  - Next cycle, lane0 beat regi=16, data 0xDEAD, with done.
  - -> wr_data[31:0]=0xDEADBEEF, wr_be=0x000F, wr_valid two cycles after the first beat.
- Backpressure: hold wr_ready=0 for 5 cycles in WRITE, then raise it -> wr_valid steady and data/be unchanged throughout; wb_done is a single pulse one cycle after the handshake; busy falls in the same cycle.
- Overflow and inactive lanes: vsew=1, nb_lanes=0.
  - lane0 regi=120, data 0xFFFF (dropped).
  - lane1 valid with data 0xAAAA (ignored).
  - lane0 done beat regi=0, data 0x1234.
  - -> ovf=1, wr_be=0x0003, wr_data[15:0]=0x1234, bytes 15..2 zero.
- Same-cycle overlap: vsew=0, lanes 0 and 2 both regi=8 with data 0x55/0x77, done -> wr_data[15:8]=0x77, wr_be=0x0002.
- Reset mid-COLLECT after two beats, then start a new collection with one done beat regi=0, data 0x01 -> no wr_valid before the new done; the new wr_data=0x01 and wr_be=0x0001, with no stale data.
